vga_frame_sink: RTL and testbench

// Display-side consumer of the processed pixel stream: accepts random-order pixel

---
 rtl/vga_frame_sink_pkg.sv | 32 +++
 rtl/vga_frame_sink_if.sv | 17 +
 rtl/vga_frame_sink_frame_ram.sv | 33 +++
 rtl/vga_frame_sink.sv | 149 ++++++++++++++
 tb/tb_vga_frame_sink.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_frame_sink_pkg.sv
// Shared VGA 640x480@60 timing constants, colour word layout and scan region codes.
package vga_frame_sink_pkg;

    localparam int CHAN_W  = 3;
    localparam int RGB_W   = 3 * CHAN_W;
    localparam int CNT_W   = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        REGION_BLANK,
        REGION_BORDER,
        REGION_IMAGE
    } region_e;

endpackage

// File: rtl/vga_frame_sink_if.sv
// Pixel write bus from the processing pipeline: one pixel per clock, no backpressure.
interface vga_frame_sink_if
    import vga_frame_sink_pkg::*;
#(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
);
    logic [WIDTH_BITS-1:0]  iX;
    logic [HEIGHT_BITS-1:0] iY;
    logic [CHAN_W-1:0]      iR;
    logic [CHAN_W-1:0]      iG;
    logic [CHAN_W-1:0]      iB;
    logic                   iWren;

    modport master (output iX, iY, iR, iG, iB, iWren);
    modport slave  (input  iX, iY, iR, iG, iB, iWren);
endinterface

// File: rtl/vga_frame_sink_frame_ram.sv
// Simple dual-port frame buffer; 1-clock registered read, read-before-write on collision.
// Write port is always ready; read data holds until the next read enable.
module vga_frame_sink_frame_ram
    import vga_frame_sink_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = RGB_W
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem_q [1 << AW];
    logic [DW-1:0] rd_dat_q;

    // Both updates are non-blocking, so a same-address read sees the pre-write word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem_q[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/vga_frame_sink.sv
// Frame buffer plus VGA scan-out; image centred, border colour elsewhere in active area.
// Outputs lag the h/v counters by one pixel tick; pixel writes are never stalled.
module vga_frame_sink
    import vga_frame_sink_pkg::*;
#(
    parameter int                WIDTH_BITS  = 8,
    parameter int                HEIGHT_BITS = 8,
    parameter int                CLK_DIV     = 2,
    parameter int                H_ORIGIN    = 192,
    parameter int                V_ORIGIN    = 112,
    parameter logic [RGB_W-1:0]  BORDER_RGB  = 9'h000,
    parameter int                H_ACT       = H_ACTIVE,
    parameter int                H_FP        = H_FRONT,
    parameter int                H_SYN       = H_SYNC,
    parameter int                H_BP        = H_BACK,
    parameter int                V_ACT       = V_ACTIVE,
    parameter int                V_FP        = V_FRONT,
    parameter int                V_SYN       = V_SYNC,
    parameter int                V_BP        = V_BACK
) (
    input  logic              clock,
    input  logic              not_reset,
    vga_frame_sink_if.slave   wr,
    output logic [CHAN_W-1:0] oVGA_R,
    output logic [CHAN_W-1:0] oVGA_G,
    output logic [CHAN_W-1:0] oVGA_B,
    output logic              oVGA_HS,
    output logic              oVGA_VS,
    output logic              oFrameStart
);

    localparam int               DIV_W  = $clog2(CLK_DIV);
    localparam int               AW     = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACT + H_FP + H_SYN + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACT + V_FP + V_SYN + V_BP - 1);

    logic [DIV_W-1:0]       div_q, div_d;
    logic [CNT_W-1:0]       h_q, h_d, v_q, v_d;
    logic                   tick;

    logic                   h_in_img, v_in_img, in_active;
    region_e                region_d, region_q;
    logic                   hs_d, vs_d, hs1_q, vs1_q;
    rgb_t                   rgb_d, rgb_q;
    logic                   hs_q, vs_q;
    logic                   fs_d, fs_q;

    logic [WIDTH_BITS-1:0]  h_off;
    logic [HEIGHT_BITS-1:0] v_off;
    logic [AW-1:0]          rd_addr;
    logic [RGB_W-1:0]       rd_raw;
    logic                   wr_en;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    // Image window is clipped to the active area so small timings never leak pixels into blanking.
    assign h_in_img  = (int'(h_q) >= H_ORIGIN) && (int'(h_q) < H_ORIGIN + (1 << WIDTH_BITS));
    assign v_in_img  = (int'(v_q) >= V_ORIGIN) && (int'(v_q) < V_ORIGIN + (1 << HEIGHT_BITS));
    assign in_active = (int'(h_q) < H_ACT) && (int'(v_q) < V_ACT);

    always_comb begin
        region_d = REGION_BLANK;
        if (in_active) begin
            region_d = (h_in_img && v_in_img) ? REGION_IMAGE : REGION_BORDER;
        end
        hs_d = !((int'(h_q) >= H_ACT + H_FP) && (int'(h_q) < H_ACT + H_FP + H_SYN));
        vs_d = !((int'(v_q) >= V_ACT + V_FP) && (int'(v_q) < V_ACT + V_FP + V_SYN));
        fs_d = tick && (h_q == '0) && (v_q == '0);
    end

    assign h_off   = WIDTH_BITS'(h_q - CNT_W'(H_ORIGIN));
    assign v_off   = HEIGHT_BITS'(v_q - CNT_W'(V_ORIGIN));
    assign rd_addr = {v_off, h_off};

    always_comb begin
        case (region_q)
            REGION_IMAGE:  rgb_d = rgb_t'(rd_raw);
            REGION_BORDER: rgb_d = rgb_t'(BORDER_RGB);
            default:       rgb_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            region_q <= REGION_BLANK;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            rgb_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            fs_q  <= fs_d;
            // Flags wait one tick for the RAM word so colour and syncs leave together.
            if (tick) begin
                region_q <= region_d;
                hs1_q    <= hs_d;
                vs1_q    <= vs_d;
                rgb_q    <= rgb_d;
                hs_q     <= hs1_q;
                vs_q     <= vs1_q;
            end
        end
    end

    assign wr_en = wr.iWren && not_reset;

    vga_frame_sink_frame_ram #(
        .AW (AW),
        .DW (RGB_W)
    ) u_frame_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr ({wr.iY, wr.iX}),
        .wr_dat  ({wr.iR, wr.iG, wr.iB}),
        .rd_en   (tick),
        .rd_addr (rd_addr),
        .rd_dat  (rd_raw)
    );

    assign oVGA_R      = rgb_q.r;
    assign oVGA_G      = rgb_q.g;
    assign oVGA_B      = rgb_q.b;
    assign oVGA_HS     = hs_q;
    assign oVGA_VS     = vs_q;
    assign oFrameStart = fs_q;

endmodule

// File: tb/tb_vga_frame_sink.sv
// Directed bench for vga_frame_sink using a shrunken raster so several frames fit in a short run.
module tb_vga_frame_sink;

    localparam int D   = 2;
    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HSY = 8;
    localparam int HBP = 4;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VA  = 40;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 4;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int HO  = 8;
    localparam int VO  = 4;
    localparam int F   = HT * VT * D;

    logic       clock = 1'b0;
    logic       not_reset = 1'b0;
    logic [2:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, frame_start;

    int cyc = 0;
    int nvec = 0;
    int nfail = 0;
    int cr, c0, c1, c2, c3, t_fall, t_rise, t_fall2;

    vga_frame_sink_if #(.WIDTH_BITS(8), .HEIGHT_BITS(8)) wr_if ();

    vga_frame_sink #(
        .WIDTH_BITS  (8),
        .HEIGHT_BITS (8),
        .CLK_DIV     (D),
        .H_ORIGIN    (HO),
        .V_ORIGIN    (VO),
        .BORDER_RGB  (9'h049),
        .H_ACT       (HA),
        .H_FP        (HFP),
        .H_SYN       (HSY),
        .H_BP        (HBP),
        .V_ACT       (VA),
        .V_FP        (VFP),
        .V_SYN       (VSY),
        .V_BP        (VBP)
    ) dut (
        .clock       (clock),
        .not_reset   (not_reset),
        .wr          (wr_if),
        .oVGA_R      (vga_r),
        .oVGA_G      (vga_g),
        .oVGA_B      (vga_b),
        .oVGA_HS     (vga_hs),
        .oVGA_VS     (vga_vs),
        .oFrameStart (frame_start)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto_cyc(input string tag, input int target);
        if (cyc > target) begin
            nvec++;
            nfail++;
            $error("FAIL %s: observed cycle %0d expected at most %0d", tag, cyc, target);
        end
        while (cyc < target) @(negedge clock);
    endtask

    // Pixel (h,v) of the frame whose start pulse was seen at cycle base.
    task automatic check_px(input string tag, input int base, input int h, input int v,
                            input logic [31:0] exp);
        goto_cyc(tag, base + (v * HT + h + 1) * D);
        check(tag, 32'({vga_r, vga_g, vga_b}), exp);
    endtask

    task automatic write_px(input int x, input int y, input logic [8:0] rgb);
        wr_if.iX    = 8'(x);
        wr_if.iY    = 8'(y);
        wr_if.iR    = rgb[8:6];
        wr_if.iG    = rgb[5:3];
        wr_if.iB    = rgb[2:0];
        wr_if.iWren = 1'b1;
        @(negedge clock);
        wr_if.iWren = 1'b0;
    endtask

    task automatic wait_fs(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 20000 && at < 0; i++) begin
            if (frame_start === 1'b1) at = cyc;
            else @(negedge clock);
        end
        if (at < 0) begin
            nvec++;
            nfail++;
            $error("FAIL %s: observed no frame start expected one within 20000 cycles", tag);
            at = cyc;
        end
    endtask

    task automatic wait_hs(input string tag, input logic lvl, output int at);
        at = -1;
        for (int i = 0; i < 2000 && at < 0; i++) begin
            if (vga_hs === lvl) at = cyc;
            else @(negedge clock);
        end
        if (at < 0) begin
            nvec++;
            nfail++;
            $error("FAIL %s: observed no HS=%0b expected within 2000 cycles", tag, lvl);
            at = cyc;
        end
    endtask

    initial begin
        wr_if.iX    = '0;
        wr_if.iY    = '0;
        wr_if.iR    = '0;
        wr_if.iG    = '0;
        wr_if.iB    = '0;
        wr_if.iWren = 1'b0;

        repeat (5) @(negedge clock);
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        check("rst_hs", 32'(vga_hs), 32'd1);
        check("rst_vs", 32'(vga_vs), 32'd1);
        check("rst_fs", 32'(frame_start), 32'd0);

        not_reset = 1'b1;
        cr = cyc;
        wait_fs("fs_after_reset", c0);
        check("fs_after_reset", 32'(c0 - cr), 32'(D));
        @(negedge clock);
        check("fs_width", 32'(frame_start), 32'd0);

        write_px(10, 20, 9'h1FF);
        write_px(11, 20, 9'h038);
        write_px(30, 5, 9'h111);
        write_px(30, 5, 9'h0C3);
        write_px(0, 0, 9'h00F);
        write_px(5, 5, 9'h007);

        wait_hs("hs_fall", 1'b0, t_fall);
        check("hs_fall", 32'(t_fall - c0), 32'((HA + HFP + 1) * D));
        wait_hs("hs_rise", 1'b1, t_rise);
        check("hs_width", 32'(t_rise - t_fall), 32'(HSY * D));
        wait_hs("hs_fall2", 1'b0, t_fall2);
        check("line_len", 32'(t_fall2 - t_fall), 32'(HT * D));

        check_px("border_top", c0, 20, 2, 32'h049);
        check_px("blank_right", c0, 70, 2, 32'h000);
        check_px("img_origin", c0, HO, VO, 32'h00F);
        check_px("img_5_5", c0, HO + 5, VO + 5, 32'h007);
        check_px("last_write", c0, HO + 30, VO + 5, 32'h0C3);
        check_px("border_left", c0, 3, VO + 20, 32'h049);
        check_px("img_10_20", c0, HO + 10, VO + 20, 32'h1FF);
        check_px("img_11_20", c0, HO + 11, VO + 20, 32'h038);

        goto_cyc("vs_41", c0 + ((VA + VFP - 1) * HT + HT - 1 + 1) * D);
        check("vs_41", 32'(vga_vs), 32'd1);
        goto_cyc("vs_42", c0 + ((VA + VFP) * HT + 1) * D);
        check("vs_42", 32'(vga_vs), 32'd0);
        goto_cyc("vs_43", c0 + ((VA + VFP + 1) * HT + HT - 1 + 1) * D);
        check("vs_43", 32'(vga_vs), 32'd0);
        goto_cyc("vs_44", c0 + ((VA + VFP + VSY) * HT + 1) * D);
        check("vs_44", 32'(vga_vs), 32'd1);

        wait_fs("frame_len", c1);
        check("frame_len", 32'(c1 - c0), 32'(F));

        // Write lands on the same edge that issues the read of image (0,0).
        goto_cyc("collide_wr", c1 + (VO * HT + HO) * D - 1);
        write_px(0, 0, 9'h0F0);
        check_px("collide_old", c1, HO, VO, 32'h00F);

        wait_fs("frame_len2", c2);
        check("frame_len2", 32'(c2 - c1), 32'(F));
        check_px("collide_new", c2, HO, VO, 32'h0F0);

        goto_cyc("pre_rst", c2 + ((VA + VFP) * HT + 70 + 1) * D);
        check("pre_rst_hs", 32'(vga_hs), 32'd0);
        check("pre_rst_vs", 32'(vga_vs), 32'd0);
        #1 not_reset = 1'b0;
        #1;
        check("mid_rst_hs", 32'(vga_hs), 32'd1);
        check("mid_rst_vs", 32'(vga_vs), 32'd1);
        check("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        write_px(5, 5, 9'h1FF);
        repeat (3) @(negedge clock);

        not_reset = 1'b1;
        cr = cyc;
        wait_fs("fs_after_midrst", c3);
        check("fs_after_midrst", 32'(c3 - cr), 32'(D));
        check_px("kept_origin", c3, HO, VO, 32'h0F0);
        check_px("rst_write_ignored", c3, HO + 5, VO + 5, 32'h007);
        check_px("kept_10_20", c3, HO + 10, VO + 20, 32'h1FF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
